// File: rtl/blur_frame_ctrl.sv
// Frame sequencer for face_blur: streams one W x H source frame into the filter
// as an unbroken burst and captures the 16-bit result into destination memory.
module blur_frame_ctrl #(
  parameter int W       = 210,
  parameter int H       = 300,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic [15:0]       iEPS,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic              oSRC_RD,
  output logic [ADDR_W-1:0] oSRC_ADDR,
  input  logic [7:0]        iSRC_DATA,
  output logic              oF_DVAL,
  output logic [7:0]        oF_DATA,
  output logic [15:0]       oF_EPS,
  input  logic              iF_DVAL,
  input  logic [15:0]       iF_DATA,
  output logic              oDST_WE,
  output logic [ADDR_W-1:0] oDST_ADDR,
  output logic [15:0]       oDST_DATA
);

  localparam int N = W * H;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] IDLE_LIMIT = ADDR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} stateT;

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] srcCnt;
  logic [ADDR_W-1:0] outCnt;
  logic [ADDR_W-1:0] idleCnt;
  logic              rdD1;
  logic              startAcc;
  logic              capture;
  logic              finalBeat;
  logic              timeoutHit;

  assign startAcc   = (state == S_IDLE) && iSTART;
  // Capture only while busy; reaching N beats leaves FEED/DRAIN, so outCnt never passes N-1 here.
  assign capture    = iF_DVAL && ((state == S_FEED) || (state == S_DRAIN));
  assign finalBeat  = capture && (outCnt == LAST_ADDR);
  // A beat on the expiry cycle wins because timeoutHit requires no beat.
  assign timeoutHit = (state == S_DRAIN) && !iF_DVAL && (idleCnt == IDLE_LIMIT);
  assign oSRC_ADDR  = srcCnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: begin
        if (iSTART) nextState = S_FEED;
      end
      S_FEED: begin
        if (finalBeat) nextState = S_DONE;
        else if (srcCnt == LAST_ADDR) nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (finalBeat || timeoutHit) nextState = S_DONE;
      end
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    oBUSY   = 1'b0;
    oDONE   = 1'b0;
    oSRC_RD = 1'b0;
    case (state)
      S_FEED: begin
        oBUSY   = 1'b1;
        oSRC_RD = 1'b1;
      end
      S_DRAIN: oBUSY = 1'b1;
      S_DONE:  oDONE = 1'b1;
      default: ;
    endcase
  end

  // Source read has one cycle of latency, so the filter sees data two cycles after the read.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      srcCnt  <= '0;
      rdD1    <= 1'b0;
      oF_DVAL <= 1'b0;
      oF_DATA <= '0;
    end else begin
      if (state == S_FEED) begin
        srcCnt <= (srcCnt == LAST_ADDR) ? '0 : srcCnt + ONE;
      end else begin
        srcCnt <= '0;
      end
      rdD1    <= oSRC_RD;
      oF_DVAL <= rdD1;
      oF_DATA <= rdD1 ? iSRC_DATA : 8'h00;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oF_EPS    <= '0;
      oERR      <= 1'b0;
      outCnt    <= '0;
      idleCnt   <= '0;
      oDST_WE   <= 1'b0;
      oDST_ADDR <= '0;
      oDST_DATA <= '0;
    end else begin
      oDST_WE <= capture;
      if (startAcc) begin
        oF_EPS  <= iEPS;
        oERR    <= 1'b0;
        outCnt  <= '0;
        idleCnt <= '0;
      end else begin
        if (capture) begin
          oDST_ADDR <= outCnt;
          oDST_DATA <= iF_DATA;
          outCnt    <= outCnt + ONE;
        end
        if (capture) begin
          idleCnt <= '0;
        end else if (state == S_DRAIN) begin
          idleCnt <= idleCnt + ONE;
        end
        if (timeoutHit) oERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// Bench for blur_frame_ctrl: a source memory and a delaying identity filter model
// drive a small 4x3 instance and a full-size 210x300 instance.
module tb_blur_frame_ctrl;

  localparam int SN = 12;
  localparam int ST = 16;
  localparam int BN = 63000;
  localparam int BD = 700;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic        start, busy, done, err, srcRd, fDvalO, fDvalI, dstWe;
  logic [15:0] epsIn, srcAddr, fEps, fDataI, dstAddr, dstData;
  logic [7:0]  srcData, fDataO;

  logic        bStart, bBusy, bDone, bErr, bSrcRd, bFDvalO, bFDvalI, bDstWe;
  logic [15:0] bEps, bSrcAddr, bFEps, bFDataI, bDstAddr, bDstData;
  logic [7:0]  bSrcData, bFDataO;

  int total = 0;
  int bad = 0;

  logic [7:0]  srcMem [0:SN-1];
  logic        schV [0:255];
  logic [15:0] schD [0:255];
  logic [7:0]  bigMem [0:BN-1];
  logic        bigV [0:1023];
  logic [15:0] bigD [0:1023];

  blur_frame_ctrl #(.W(4), .H(3), .ADDR_W(16), .TIMEOUT(ST)) dut (
    .iCLK(clk), .iRST_N(rstN), .iSTART(start), .iEPS(epsIn),
    .oBUSY(busy), .oDONE(done), .oERR(err),
    .oSRC_RD(srcRd), .oSRC_ADDR(srcAddr), .iSRC_DATA(srcData),
    .oF_DVAL(fDvalO), .oF_DATA(fDataO), .oF_EPS(fEps),
    .iF_DVAL(fDvalI), .iF_DATA(fDataI),
    .oDST_WE(dstWe), .oDST_ADDR(dstAddr), .oDST_DATA(dstData)
  );

  blur_frame_ctrl dutBig (
    .iCLK(clk), .iRST_N(rstN), .iSTART(bStart), .iEPS(bEps),
    .oBUSY(bBusy), .oDONE(bDone), .oERR(bErr),
    .oSRC_RD(bSrcRd), .oSRC_ADDR(bSrcAddr), .iSRC_DATA(bSrcData),
    .oF_DVAL(bFDvalO), .oF_DATA(bFDataO), .oF_EPS(bFEps),
    .iF_DVAL(bFDvalI), .iF_DATA(bFDataI),
    .oDST_WE(bDstWe), .oDST_ADDR(bDstAddr), .oDST_DATA(bDstData)
  );

  // One frame on the small instance. Cycle c counts edges after the start edge.
  // Filter beat k is emitted d cycles after input pixel k (plus gapExtra for k >= gapIdx),
  // only the first lim beats are emitted, and 'extra' junk beats follow the last one.
  task automatic run_frame(input string name, input logic [15:0] eps, input int d,
                           input int lim, input int gapIdx, input int gapExtra,
                           input int extra, input int midStart, input int post,
                           input int expDone, input int expWrites, input logic expErr);
    int c, inCnt, pendAddr, writes, off, sl;
    logic pend, expDv;
    logic [7:0] expData;
    for (int i = 0; i < 256; i++) begin
      schV[i] = 1'b0;
      schD[i] = '0;
    end
    for (int i = 0; i < SN; i++) srcMem[i] = 8'($urandom);
    c = 0; inCnt = 0; pend = 1'b0; pendAddr = 0; writes = 0;
    start = 1'b1;
    epsIn = eps;
    while (c < expDone + post) begin
      @(negedge clk);
      c++;
      start = (c == midStart);
      epsIn = (c == midStart) ? 16'd50 : 16'($urandom);
      srcData = pend ? srcMem[pendAddr] : 8'($urandom);
      pend = (srcRd === 1'b1) && (srcAddr < 16'(SN));
      pendAddr = int'(srcAddr);
      sl = c % 256;
      fDvalI = schV[sl];
      fDataI = schV[sl] ? schD[sl] : 16'($urandom);
      schV[sl] = 1'b0;
      if (fDvalO === 1'b1) begin
        off = d + ((inCnt >= gapIdx) ? gapExtra : 0);
        if (inCnt < lim) begin
          schV[(c + off) % 256] = 1'b1;
          schD[(c + off) % 256] = {8'h00, fDataO};
        end
        if (inCnt == SN - 1) begin
          for (int k = 1; k <= extra; k++) begin
            schV[(c + off + k) % 256] = 1'b1;
            schD[(c + off + k) % 256] = 16'($urandom);
          end
        end
        inCnt++;
      end
      total++;
      if (srcRd !== (c <= SN) || (c <= SN && srcAddr !== 16'(c - 1))) begin
        bad++;
        $display("FAIL %s src_rd c=%0d: got rd=%b addr=%0d, want rd=%b addr=%0d",
                 name, c, srcRd, srcAddr, (c <= SN), c - 1);
      end
      expDv = (c >= 3) && (c <= SN + 2);
      expData = 8'h00;
      if (expDv) expData = srcMem[c - 3];
      total++;
      if (fDvalO !== expDv || fDataO !== expData) begin
        bad++;
        $display("FAIL %s feed c=%0d: got dval=%b data=%h, want dval=%b data=%h",
                 name, c, fDvalO, fDataO, expDv, expData);
      end
      total++;
      if (fEps !== eps) begin
        bad++;
        $display("FAIL %s eps c=%0d: got %0d want %0d", name, c, fEps, eps);
      end
      total++;
      if (busy !== (c < expDone) || done !== (c == expDone)) begin
        bad++;
        $display("FAIL %s busy_done c=%0d: got busy=%b done=%b, want busy=%b done=%b",
                 name, c, busy, done, (c < expDone), (c == expDone));
      end
      total++;
      if (err !== ((c >= expDone) ? expErr : 1'b0)) begin
        bad++;
        $display("FAIL %s err c=%0d: got %b want %b", name, c, err,
                 (c >= expDone) ? expErr : 1'b0);
      end
      if (dstWe === 1'b1) begin
        total++;
        if (writes >= SN || dstAddr !== 16'(writes) || dstData !== {8'h00, srcMem[writes]}) begin
          bad++;
          $display("FAIL %s write c=%0d #%0d: got addr=%0d data=%h", name, c, writes,
                   dstAddr, dstData);
        end
        writes++;
      end
    end
    start = 1'b0;
    fDvalI = 1'b0;
    total++;
    if (writes !== expWrites) begin
      bad++;
      $display("FAIL %s write_count: got %0d want %0d", name, writes, expWrites);
    end
    $display("frame %s: writes=%0d done_cycle=%0d err=%b", name, writes, expDone, err);
  endtask

  task automatic test_reset();
    logic [77:0] outs;
    @(negedge clk);
    outs = {busy, done, err, srcRd, srcAddr, fDvalO, fDataO, fEps, dstWe, dstAddr, dstData};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || srcRd !== 1'b0 || done !== 1'b0 || bBusy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle: got busy=%b rd=%b done=%b bigbusy=%b want 0",
                 busy, srcRd, done, bBusy);
      end
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_identity();
    run_frame("identity", 16'd800, 5, SN, 99, 0, 0, 0, 4, 3 + 5 + SN, SN, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_frame("mid_start", 16'd800, 5, SN, 99, 0, 0, 5, 4, 20, SN, 1'b0);
    run_frame("done_start", 16'd800, 5, SN, 99, 0, 0, 20, 5, 20, SN, 1'b0);
  endtask

  task automatic test_timeout();
    // Last of 10 beats written in cycle 18; expiry TIMEOUT cycles later.
    run_frame("timeout", 16'd800, 5, 10, 99, 0, 0, 0, 6, 18 + ST, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (err !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL err_sticky: got err=%b done=%b want err=1 done=0", err, done);
      end
    end
    run_frame("after_timeout", 16'($urandom), 5, SN, 99, 0, 0, 0, 4, 20, SN, 1'b0);
  endtask

  task automatic test_beat_vs_timeout();
    // 15 empty cycles before the final beat: the beat lands on the expiry cycle and wins.
    run_frame("beat_wins", 16'($urandom), 5, SN, 11, 15, 0, 0, 4, 35, SN, 1'b0);
    // 16 empty cycles: expiry first, the late beat is ignored.
    run_frame("gap_timeout", 16'($urandom), 5, SN, 11, 16, 0, 0, 6, 19 + ST, 11, 1'b1);
  endtask

  task automatic test_extra_beats();
    run_frame("extra_beats", 16'($urandom), 5, SN, 99, 0, 3, 0, 8, 20, SN, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 16'($urandom), 3, SN, 99, 0, 0, 0, 1, 3 + 3 + SN, SN, 1'b0);
    run_frame("b2b_second", 16'($urandom), 7, SN, 99, 0, 0, 0, 4, 3 + 7 + SN, SN, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [77:0] outs;
    logic found;
    found = 1'b0;
    epsIn = 16'd800;
    start = 1'b1;
    fDvalI = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      srcData = 8'($urandom);
      if (srcRd === 1'b1 && srcAddr === 16'd5) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_reach: got no read of address 5 want one");
    end
    rstN = 1'b0;
    #1;
    outs = {busy, done, err, srcRd, srcAddr, fDvalO, fDataO, fEps, dstWe, dstAddr, dstData};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", outs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_done: got done=%b busy=%b want 0", done, busy);
      end
    end
    rstN = 1'b1;
    $display("reset_mid: aborted at address 5");
    run_frame("after_reset", 16'($urandom), 5, SN, 99, 0, 0, 0, 4, 20, SN, 1'b0);
  endtask

  task automatic test_full_frame();
    int c, writes, dones, pendAddr, sl, expDone;
    logic pend;
    for (int i = 0; i < 1024; i++) bigV[i] = 1'b0;
    for (int i = 0; i < BN; i++) bigMem[i] = 8'($urandom);
    c = 0; writes = 0; dones = 0; pend = 1'b0; pendAddr = 0;
    expDone = 3 + BD + BN;
    bStart = 1'b1;
    bEps = 16'd800;
    while (c < expDone + 2) begin
      @(negedge clk);
      c++;
      bStart = 1'b0;
      bEps = 16'($urandom);
      bSrcData = pend ? bigMem[pendAddr] : 8'($urandom);
      pend = (bSrcRd === 1'b1) && (bSrcAddr < 16'(BN));
      pendAddr = int'(bSrcAddr);
      sl = c % 1024;
      bFDvalI = bigV[sl];
      bFDataI = bigD[sl];
      bigV[sl] = 1'b0;
      if (bFDvalO === 1'b1) begin
        bigV[(c + BD) % 1024] = 1'b1;
        bigD[(c + BD) % 1024] = {8'h00, bFDataO};
      end
      if (bDstWe === 1'b1) begin
        total++;
        if (writes >= BN || bDstAddr !== 16'(writes) || bDstData !== {8'h00, bigMem[writes]}) begin
          bad++;
          $display("FAIL full_write #%0d: got addr=%0d data=%h", writes, bDstAddr, bDstData);
        end
        writes++;
      end
      if (bDone === 1'b1) begin
        dones++;
        total++;
        if (c !== expDone || bErr !== 1'b0 || bFEps !== 16'd800) begin
          bad++;
          $display("FAIL full_done: got cycle=%0d err=%b eps=%0d want cycle=%0d err=0 eps=800",
                   c, bErr, bFEps, expDone);
        end
      end
    end
    bFDvalI = 1'b0;
    total++;
    if (writes !== BN || dones !== 1) begin
      bad++;
      $display("FAIL full_count: got writes=%0d dones=%0d want %0d and 1", writes, dones, BN);
    end
    $display("frame full: writes=%0d dones=%0d", writes, dones);
  endtask

  initial begin
    start = 1'b0; epsIn = '0; srcData = '0; fDvalI = 1'b0; fDataI = '0;
    bStart = 1'b0; bEps = '0; bSrcData = '0; bFDvalI = 1'b0; bFDataI = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_start_ignored();
    test_timeout();
    test_beat_vs_timeout();
    test_extra_beats();
    test_back_to_back();
    test_reset_mid();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
